// File: rtl/pid_filter.sv
// Velocity-form PID stage: setpoint error -> three-tap gain sum -> saturated control word.
// Define PID_OUT_LIMIT_EN to add latched out_min_in/out_max_in output limits.
module pid_filter #(
    parameter int W_IN       = 18,
    parameter int W_OUT      = 18,
    parameter int W_COEF     = 16,
    parameter int GAIN_SHIFT = 8,
    parameter int SETP_INIT  = 0,
    parameter int P_INIT     = 0,
    parameter int I_INIT     = 0,
    parameter int D_INIT     = 0
) (
    input  logic                     clk_in,
    input  logic                     reset_n_in,
    input  logic signed [W_IN-1:0]   data_in,
    input  logic                     data_valid_in,
    input  logic signed [W_IN-1:0]   setpoint_in,
    input  logic signed [W_COEF-1:0] p_coef_in,
    input  logic signed [W_COEF-1:0] i_coef_in,
    input  logic signed [W_COEF-1:0] d_coef_in,
    input  logic                     lock_en_in,
    input  logic                     update_en_in,
    input  logic                     update_in,
`ifdef PID_OUT_LIMIT_EN
    input  logic signed [W_OUT-1:0]  out_max_in,
    input  logic signed [W_OUT-1:0]  out_min_in,
`endif
    output logic signed [W_OUT-1:0]  data_out,
    output logic                     data_valid_out,
    output logic [2:0]               state_dbg
);

    localparam int KW = W_COEF + 2;
    localparam int EW = W_IN + 1;
    localparam int PW = KW + EW;
    localparam int SW = PW + 2;
    localparam int AW = W_OUT + W_COEF + 4;

    localparam logic signed [W_OUT-1:0] OUT_MAX = {1'b0, {(W_OUT-1){1'b1}}};
    localparam logic signed [W_OUT-1:0] OUT_MIN = {1'b1, {(W_OUT-1){1'b0}}};

    localparam logic signed [W_COEF-1:0] P0 = W_COEF'(P_INIT);
    localparam logic signed [W_COEF-1:0] I0 = W_COEF'(I_INIT);
    localparam logic signed [W_COEF-1:0] D0 = W_COEF'(D_INIT);
    localparam logic signed [KW-1:0] K1_INIT = KW'(P0) + KW'(I0) + KW'(D0);
    localparam logic signed [KW-1:0] K2_INIT = -(KW'(P0) + (KW'(D0) <<< 1));
    localparam logic signed [KW-1:0] K3_INIT = KW'(D0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERR  = 3'd1,
        ST_MULT = 3'd2,
        ST_SUM  = 3'd3,
        ST_SEND = 3'd4
    } state_t;

    state_t state;

    // Frontpanel copy (latched on update) and the per-sample snapshot the datapath uses.
    logic signed [W_IN-1:0] setp_q, setp_a;
    logic signed [KW-1:0]   k1_q, k2_q, k3_q;
    logic signed [KW-1:0]   k1_a, k2_a, k3_a;
`ifdef PID_OUT_LIMIT_EN
    logic signed [W_OUT-1:0] out_max_q, out_min_q;
`endif

    logic signed [W_IN-1:0]  data_q;
    logic signed [EW-1:0]    e0, e1, e2;
    logic signed [PW-1:0]    prod1, prod2, prod3;
    logic signed [W_OUT-1:0] u;

    logic signed [KW-1:0]    k1_new, k2_new, k3_new;
    logic signed [SW-1:0]    sum;
    logic signed [SW-1:0]    delta;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    hi, lo;
    logic signed [W_OUT-1:0] hi_w, lo_w;
    logic signed [W_OUT-1:0] u_next;

    assign state_dbg = state;

    always_comb begin
        k1_new = KW'(p_coef_in) + KW'(i_coef_in) + KW'(d_coef_in);
        k2_new = -(KW'(p_coef_in) + (KW'(d_coef_in) <<< 1));
        k3_new = KW'(d_coef_in);
    end

    // u is kept post-clamp so the integral term cannot wind up past the limits.
    always_comb begin
        sum   = SW'(prod1) + SW'(prod2) + SW'(prod3);
        delta = sum >>> GAIN_SHIFT;
        acc   = AW'(u) + AW'(delta);
        hi_w  = OUT_MAX;
        lo_w  = OUT_MIN;
`ifdef PID_OUT_LIMIT_EN
        hi_w  = out_max_q;
        lo_w  = out_min_q;
`endif
        hi = AW'(hi_w);
        lo = AW'(lo_w);
        if (acc > hi) begin
            u_next = hi_w;
        end else if (acc < lo) begin
            u_next = lo_w;
        end else begin
            u_next = acc[W_OUT-1:0];
        end
`ifdef PID_OUT_LIMIT_EN
        if (out_min_q > out_max_q) begin
            u_next = out_min_q;
        end
`endif
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state          <= ST_IDLE;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            setp_q         <= W_IN'(SETP_INIT);
            setp_a         <= W_IN'(SETP_INIT);
            k1_q           <= K1_INIT;
            k2_q           <= K2_INIT;
            k3_q           <= K3_INIT;
            k1_a           <= K1_INIT;
            k2_a           <= K2_INIT;
            k3_a           <= K3_INIT;
`ifdef PID_OUT_LIMIT_EN
            out_max_q      <= OUT_MAX;
            out_min_q      <= OUT_MIN;
`endif
            data_q         <= '0;
            e0             <= '0;
            e1             <= '0;
            e2             <= '0;
            prod1          <= '0;
            prod2          <= '0;
            prod3          <= '0;
            u              <= '0;
        end else begin
            data_valid_out <= 1'b0;

            if (update_in && update_en_in) begin
                setp_q <= setpoint_in;
                k1_q   <= k1_new;
                k2_q   <= k2_new;
                k3_q   <= k3_new;
`ifdef PID_OUT_LIMIT_EN
                out_max_q <= out_max_in;
                out_min_q <= out_min_in;
`endif
            end

            case (state)
                ST_IDLE: begin
                    if (data_valid_in) begin
                        data_q <= data_in;
                        setp_a <= setp_q;
                        k1_a   <= k1_q;
                        k2_a   <= k2_q;
                        k3_a   <= k3_q;
                        state  <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    e0    <= EW'(setp_a) - EW'(data_q);
                    e1    <= e0;
                    e2    <= e1;
                    state <= ST_MULT;
                end
                ST_MULT: begin
                    prod1 <= k1_a * e0;
                    prod2 <= k2_a * e1;
                    prod3 <= k3_a * e2;
                    state <= ST_SUM;
                end
                ST_SUM: begin
                    u              <= lock_en_in ? u_next : '0;
                    data_out       <= lock_en_in ? u_next : '0;
                    data_valid_out <= 1'b1;
                    state          <= ST_SEND;
                end
                ST_SEND: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Open loop: history and accumulator stay at zero so relock starts clean.
            if (!lock_en_in) begin
                e0 <= '0;
                e1 <= '0;
                e2 <= '0;
                u  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pid_filter.sv
// Directed bench for pid_filter: driver pushes expected words/cycles, monitor pops on data_valid_out.
module tb_pid_filter;

    localparam int W_IN   = 18;
    localparam int W_OUT  = 18;
    localparam int W_COEF = 16;

    logic                     clk_in = 1'b0;
    logic                     reset_n_in;
    logic signed [W_IN-1:0]   data_in;
    logic                     data_valid_in;
    logic signed [W_IN-1:0]   setpoint_in;
    logic signed [W_COEF-1:0] p_coef_in;
    logic signed [W_COEF-1:0] i_coef_in;
    logic signed [W_COEF-1:0] d_coef_in;
    logic                     lock_en_in;
    logic                     update_en_in;
    logic                     update_in;
`ifdef PID_OUT_LIMIT_EN
    logic signed [W_OUT-1:0]  out_max_in;
    logic signed [W_OUT-1:0]  out_min_in;
`endif
    logic signed [W_OUT-1:0]  data_out;
    logic                     data_valid_out;
    logic [2:0]               state_dbg;

    logic [W_OUT-1:0] exp_q[$];
    int               exp_cyc_q[$];
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_err = 0;

    pid_filter #(
        .W_IN(W_IN), .W_OUT(W_OUT), .W_COEF(W_COEF), .GAIN_SHIFT(8),
        .SETP_INIT(0), .P_INIT(0), .I_INIT(0), .D_INIT(0)
    ) dut (
        .clk_in        (clk_in),
        .reset_n_in    (reset_n_in),
        .data_in       (data_in),
        .data_valid_in (data_valid_in),
        .setpoint_in   (setpoint_in),
        .p_coef_in     (p_coef_in),
        .i_coef_in     (i_coef_in),
        .d_coef_in     (d_coef_in),
        .lock_en_in    (lock_en_in),
        .update_en_in  (update_en_in),
        .update_in     (update_in),
`ifdef PID_OUT_LIMIT_EN
        .out_max_in    (out_max_in),
        .out_min_in    (out_min_in),
`endif
        .data_out      (data_out),
        .data_valid_out(data_valid_out),
        .state_dbg     (state_dbg)
    );

    // Clock and cycle counter
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc = cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk_in) begin
        logic [W_OUT-1:0] e;
        int               c;
        if (reset_n_in === 1'b1 && data_valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got data_out=%0d expected no output", data_out);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("data_out", longint'(data_out), longint'($signed(e)));
                check("valid_cycle", longint'(cyc), longint'(c));
            end
        end
    end

    // Driver tasks
    task automatic set_params(input int sp, input int p, input int i, input int d, input logic en);
        @(negedge clk_in);
        setpoint_in  = W_IN'(sp);
        p_coef_in    = W_COEF'(p);
        i_coef_in    = W_COEF'(i);
        d_coef_in    = W_COEF'(d);
        update_en_in = en;
        update_in    = 1'b1;
        @(negedge clk_in);
        update_in    = 1'b0;
        update_en_in = 1'b0;
    endtask

    task automatic send(input int d, input int exp_v);
        @(negedge clk_in);
        data_in       = W_IN'(d);
        data_valid_in = 1'b1;
        exp_q.push_back(W_OUT'(exp_v));
        exp_cyc_q.push_back(cyc + 4);
        @(negedge clk_in);
        data_valid_in = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic clear_hist();
        @(negedge clk_in);
        lock_en_in = 1'b0;
        repeat (2) @(negedge clk_in);
        lock_en_in = 1'b1;
    endtask

    initial begin
        reset_n_in    = 1'b0;
        data_in       = '0;
        data_valid_in = 1'b0;
        setpoint_in   = '0;
        p_coef_in     = '0;
        i_coef_in     = '0;
        d_coef_in     = '0;
        lock_en_in    = 1'b1;
        update_en_in  = 1'b0;
        update_in     = 1'b0;
`ifdef PID_OUT_LIMIT_EN
        out_max_in    = {1'b0, {(W_OUT-1){1'b1}}};
        out_min_in    = {1'b1, {(W_OUT-1){1'b0}}};
`endif
        repeat (3) @(negedge clk_in);
        check("reset_data_out", longint'(data_out), 0);
        check("reset_valid", longint'(data_valid_out), 0);
        check("reset_state", longint'(state_dbg), 0);
        reset_n_in = 1'b1;

        // Pure P
        set_params(100, 256, 0, 0, 1'b1);
        clear_hist();
        send(0, 100);
        send(0, 100);

        // Pure I
        set_params(100, 0, 256, 0, 1'b1);
        clear_hist();
        send(0, 100);
        send(0, 200);
        send(0, 300);

        // Pure D
        set_params(0, 0, 0, 256, 1'b1);
        clear_hist();
        send(0, 0);
        send(-50, 50);
        send(-50, 0);

        // Saturation, then one step of error -1 shows no windup
        set_params(131071, 0, 256, 0, 1'b1);
        clear_hist();
        send(-131072, 131071);
        send(-131072, 131071);
        send(-131072, 131071);
        set_params(0, 0, 256, 0, 1'b1);
        send(1, 131070);

        // Open loop forces zero output
        set_params(100, 256, 0, 0, 1'b1);
        @(negedge clk_in);
        lock_en_in = 1'b0;
        send(0, 0);

        // Lock drops while a sample is in ST_MULT: that result is discarded
        @(negedge clk_in);
        lock_en_in = 1'b1;
        @(negedge clk_in);
        data_in       = '0;
        data_valid_in = 1'b1;
        exp_q.push_back(W_OUT'(0));
        exp_cyc_q.push_back(cyc + 4);
        @(negedge clk_in);
        data_valid_in = 1'b0;
        @(negedge clk_in);
        lock_en_in = 1'b0;
        repeat (3) @(negedge clk_in);
        lock_en_in = 1'b1;
        send(0, 100);

        // Second strobe two cycles after the first is dropped
        clear_hist();
        @(negedge clk_in);
        data_in       = '0;
        data_valid_in = 1'b1;
        exp_q.push_back(W_OUT'(100));
        exp_cyc_q.push_back(cyc + 4);
        @(negedge clk_in);
        data_valid_in = 1'b0;
        @(negedge clk_in);
        data_in       = W_IN'(555);
        data_valid_in = 1'b1;
        @(negedge clk_in);
        data_valid_in = 1'b0;
        repeat (4) @(negedge clk_in);

        // update_in without update_en_in leaves gains and setpoint alone
        clear_hist();
        set_params(0, 0, 0, 0, 1'b0);
        send(0, 100);

        // Async reset while in ST_MULT: no output ever appears
        clear_hist();
        @(negedge clk_in);
        data_in       = '0;
        data_valid_in = 1'b1;
        @(negedge clk_in);
        data_valid_in = 1'b0;
        @(negedge clk_in);
        check("mid_state_mult", longint'(state_dbg), 2);
        reset_n_in = 1'b0;
        #1;
        check("mid_reset_data_out", longint'(data_out), 0);
        check("mid_reset_state", longint'(state_dbg), 0);
        @(negedge clk_in);
        reset_n_in = 1'b1;
        repeat (8) @(negedge clk_in);
        check("post_reset_data_out", longint'(data_out), 0);

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk_in);
        check("expected_drained", longint'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pid_filter.md
Name: pid_filter

Overview:
- Downstream neighbour of the oversample filter in each PID channel.
- Consumes the filtered ADC word and its one-cycle valid strobe, and computes the error against a frontpanel setpoint.
- Applies a velocity-form PID update and emits a saturated control word with a one-cycle valid strobe toward output routing / DAC-DDS scaling.
- Gains, setpoint and lock control are latched from the frontpanel using the same update_en/update pulse scheme as the rest of the channel.

Parameters:
W_IN, 18, width of signed input data
W_OUT, 18, width of signed control output
W_COEF, 16, width of signed P/I/D gain inputs
GAIN_SHIFT, 8, arithmetic right shift applied to the summed products (fixed-point gain scale)
SETP_INIT, 0, initial setpoint
P_INIT, 0, initial proportional gain
I_INIT, 0, initial integral gain
D_INIT, 0, initial derivative gain

Ports:
clk_in  in  1  system clock
reset_n_in  in  1  reset, asynchronous assert, active-low
data_in  in  W_IN  signed input sample
data_valid_in  in  1  one-cycle strobe marking a new data_in
setpoint_in  in  W_IN  signed setpoint (frontpanel)
p_coef_in  in  W_COEF  signed P gain
i_coef_in  in  W_COEF  signed I gain
d_coef_in  in  W_COEF  signed D gain
lock_en_in  in  1  1 = loop closed, 0 = output forced to 0 and history cleared
update_en_in  in  1  sensitizes module to update_in
update_in  in  1  pulse latching all frontpanel parameters
data_out  out  W_OUT  signed control word
data_valid_out  out  1  one-cycle strobe for data_out

Behaviour:
- Reset (reset_n_in low, async):
  - data_out=0, data_valid_out=0, state=ST_IDLE.
  - e0/e1/e2 history = 0, accumulator u = 0.
  - Latched params take their *_INIT values.
- Param latch: on clk edge with update_in & update_en_in, register setpoint, p, i, d, and precompute:
  - k1 = p+i+d
  - k2 = -(p + 2d)
  - k3 = d
  - All three are W_COEF+2 bits signed.
  - Takes effect for the next sample accepted after the latch cycle.
- FSM:
  - ST_IDLE: on data_valid_in, capture data_in, go to ST_ERR.
  - ST_ERR: e0 = setpoint - data (W_IN+1 bits signed, no overflow); shift e0->e1->e2 so the history holds current, previous and previous-previous errors.
  - ST_MULT: register k1*e0, k2*e1, k3*e2 at full width.
  - ST_SUM: delta = (sum of the three products) >>> GAIN_SHIFT; u_next = u + delta computed at W_OUT+W_COEF+4 bits, then saturated to signed W_OUT range; u <= u_next.
  - ST_SEND: data_out <= u; data_valid_out=1 for exactly this cycle; return to ST_IDLE.
- Latency: data_valid_in at cycle N -> data_valid_out at cycle N+4. data_out holds its value until the next ST_SEND.
- data_valid_in outside ST_IDLE is ignored (dropped; no queue). Upstream rate is at most 1 per 5 cycles by construction.
- Saturation (anti-windup):
  - u is stored post-clamp, so integral windup is bounded.
  - Positive clamp = 2^(W_OUT-1)-1; negative clamp = -2^(W_OUT-1).
- lock_en_in = 0:
  - u and e history are held at 0; the FSM still runs.
  - Each accepted sample produces data_valid_out with data_out=0.
  - On the 0->1 transition, the first sample starts from zero history (no derivative kick from stale data).
- lock_en_in falling mid-sequence: the in-flight result is discarded; the ST_SEND of that sample outputs 0.
- Async reset mid-sequence: immediate return to ST_IDLE; no data_valid_out.

Optional Feature:
PID_OUT_LIMIT_EN:
- Defined:
  - Adds ports out_max_in and out_min_in (W_OUT each), latched with the other parameters.
  - u saturates to [out_min, out_max] instead of the full W_OUT range.
  - If out_min > out_max, u is forced to out_min.
- Not defined: ports absent; full-range saturation only.

Test Plan:
- Pure P: GAIN_SHIFT=8, p=256, i=d=0, setpoint=100, lock=1; two samples of 0 -> data_out=100 both times, each valid exactly 4 cycles after its input.
- Pure I: i=256, p=d=0, setpoint=100; three samples of 0 -> data_out 100, 200, 300.
- Pure D: d=256, setpoint=0; samples 0, -50, -50 -> data_out 0, 50, 0 (derivative form: u accumulates 0, +50, -50).
- Saturation: W_OUT=18, i=256, setpoint=131071, data=-131072 repeated -> data_out clamps at 131071 and stays there; a single sample with error -1 then gives 131070 (no windup).
- Lock/drop:
  - lock=0 with a sample of 0 and setpoint 100 -> data_out=0.
  - data_valid_in pulsed 2 cycles after a prior one -> second sample ignored; only one data_valid_out.
- Reset/update:
  - reset_n_in low during ST_MULT -> data_valid_out never asserts; data_out=0.
  - update_in with update_en_in=0 -> gains unchanged.
